// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants used by the controller, the buffer and the system top.
package fifo_pkg;

    localparam int FIFO_DEPTH    = 8;
    localparam int FIFO_AW       = 3;
    localparam int FIFO_AF_LEVEL = 6;
    localparam int FIFO_AE_LEVEL = 2;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: AW address bits plus one MSB that toggles on every pass through the buffer.
module fifo_ptr #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [AW:0]   ptr
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// FIFO controller: write/read pointer pair, occupancy and threshold flags, sticky error flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = FIFO_AW,
    parameter int AF_LEVEL   = FIFO_AF_LEVEL,
    parameter int AE_LEVEL   = FIFO_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic                  rinc,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  wclken,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    // A threshold above capacity could never be reached, so cap it at DEPTH.
    localparam int                AF_CAP = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
    localparam logic [ADDR_WIDTH:0] AF_L = AF_CAP[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_L = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                rd_acc;
    logic                ovf_set;
    logic                unf_set;

    assign wclken  = rst & winc & ~full & ~flush;
    assign rd_acc  = rst & rinc & ~empty & ~flush;
    assign ovf_set = winc & full & ~flush;
    assign unf_set = rinc & empty & ~flush;

    fifo_ptr #(.AW(ADDR_WIDTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (wclken),
        .clr (flush),
        .ptr (wptr)
    );

    fifo_ptr #(.AW(ADDR_WIDTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .clr (flush),
        .ptr (rptr)
    );

    // All status is decoded from the registered pointers, never from this cycle's requests.
    assign waddr        = wptr[ADDR_WIDTH-1:0];
    assign raddr        = rptr[ADDR_WIDTH-1:0];
    assign count        = wptr - rptr;
    assign empty        = (wptr == rptr);
    assign full         = (waddr == raddr) && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    // A new error in the err_clr cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: reset, fill, overflow/underflow, wrap streaming, flush, mid-run reset.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic       rinc;
    logic       flush;
    logic       err_clr;
    logic       wclken;
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int vectors = 0;
    int errors  = 0;

    // Reference state: expected pointers and sticky flags.
    logic [3:0] ewp = '0;
    logic [3:0] erp = '0;
    logic       eov = 1'b0;
    logic       eun = 1'b0;

    fifo_ctrl #(
        .DEPTH      (8),
        .ADDR_WIDTH (3),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .winc         (winc),
        .rinc         (rinc),
        .flush        (flush),
        .err_clr      (err_clr),
        .wclken       (wclken),
        .waddr        (waddr),
        .raddr        (raddr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, clock, check registered outputs.
    task automatic cyc(input logic w, input logic r, input logic f, input logic c, input logic rs);
        logic [3:0] mc;
        logic       mfull;
        logic       mempty;
        logic       wa;
        logic       ra;
        winc = w; rinc = r; flush = f; err_clr = c; rst = rs;
        mc     = ewp - erp;
        mfull  = (mc == 4'd8);
        mempty = (mc == 4'd0);
        wa     = rs & w & ~mfull & ~f;
        ra     = rs & r & ~mempty & ~f;
        #1;
        check("wclken", {31'd0, wclken}, {31'd0, wa});
        check("waddr", {29'd0, waddr}, {29'd0, ewp[2:0]});
        check("raddr", {29'd0, raddr}, {29'd0, erp[2:0]});
        @(posedge clk);
        if (!rs) begin
            ewp = '0; erp = '0; eov = 1'b0; eun = 1'b0;
        end else begin
            eov = (w & mfull & ~f) | (eov & ~c);
            eun = (r & mempty & ~f) | (eun & ~c);
            if (f) begin
                ewp = '0; erp = '0;
            end else begin
                if (wa) ewp = ewp + 4'd1;
                if (ra) erp = erp + 4'd1;
            end
        end
        #1;
        mc = ewp - erp;
        check("count", {28'd0, count}, {28'd0, mc});
        check("full", {31'd0, full}, {31'd0, mc == 4'd8});
        check("empty", {31'd0, empty}, {31'd0, mc == 4'd0});
        check("almost_full", {31'd0, almost_full}, {31'd0, mc >= 4'd6});
        check("almost_empty", {31'd0, almost_empty}, {31'd0, mc <= 4'd2});
        check("overflow", {31'd0, overflow}, {31'd0, eov});
        check("underflow", {31'd0, underflow}, {31'd0, eun});
    endtask

    initial begin
        rst = 1'b0; winc = 1'b0; rinc = 1'b0; flush = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;

        // Reset with a write request pending: no write may happen.
        cyc(1, 0, 0, 0, 0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_ae", {31'd0, almost_empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_af", {31'd0, almost_full}, 32'd0);
        check("rst_waddr", {29'd0, waddr}, 32'd0);
        check("rst_raddr", {29'd0, raddr}, 32'd0);

        // Eight writes, no reads.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 1);
            check("fill_af", {31'd0, almost_full}, (i >= 5) ? 32'd1 : 32'd0);
        end
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", {28'd0, count}, 32'd8);

        // Write while full, then clear.
        cyc(1, 0, 0, 0, 1);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_count", {28'd0, count}, 32'd8);
        cyc(0, 0, 0, 1, 1);
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // Full with winc & rinc: read accepted, write rejected.
        cyc(1, 1, 0, 0, 1);
        check("full_wr_count", {28'd0, count}, 32'd7);
        check("full_wr_ovf", {31'd0, overflow}, 32'd1);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 1);
        check("ovf_beats_clr", {31'd0, overflow}, 32'd1);
        cyc(0, 0, 0, 1, 1);

        // Drain all eight entries.
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 1);
        check("drain_empty", {31'd0, empty}, 32'd1);

        // Read while empty.
        cyc(0, 1, 0, 0, 1);
        check("unf_set", {31'd0, underflow}, 32'd1);
        check("unf_raddr", {29'd0, raddr}, 32'd1);
        cyc(0, 0, 0, 1, 1);
        check("unf_clr", {31'd0, underflow}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("empty_wr_count", {28'd0, count}, 32'd1);
        check("empty_wr_unf", {31'd0, underflow}, 32'd1);

        // Build to count 4 and stream 20 read/write pairs through the wrap.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 1);
        check("stream_count", {28'd0, count}, 32'd4);

        // Count 5, then flush with both requests; sticky underflow survives.
        cyc(1, 0, 0, 0, 1);
        check("pre_flush_count", {28'd0, count}, 32'd5);
        cyc(1, 1, 1, 0, 1);
        check("flush_count", {28'd0, count}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_unf", {31'd0, underflow}, 32'd1);
        check("flush_ovf", {31'd0, overflow}, 32'd0);

        // Provoke overflow, back off to count 3, then reset mid-run.
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1);
        check("pre_rst_count", {28'd0, count}, 32'd3);
        check("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("mid_rst_count", {28'd0, count}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        check("mid_rst_waddr", {29'd0, waddr}, 32'd0);
        check("mid_rst_raddr", {29'd0, raddr}, 32'd0);
        cyc(0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_fifo_ctrl
